// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared types and constants for the cacheline memory-port arbiter
package cache_types_pkg;

  localparam int LINE_BITS = 256;
  localparam int ADDR_BITS = 32;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_I = 2'd1,
    SERV_D = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin chooser between icache and dcache
module rr_pick2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic pick_d
);

  // On contention the requester not served last wins; a lone request always wins.
  assign pick_d = req_d & (~req_i | ~last_d);

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares the single cacheline memory port between icache and dcache
module cache_arbiter
  import cache_types_pkg::*;
#(
  parameter int   LINE_W  = LINE_BITS,
  parameter int   ADDR_W  = ADDR_BITS,
  parameter logic D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        grant
);

  arb_state_e state;
  logic       last_d;
  logic       d_is_write;
  logic       req_d;
  logic       pick_d;

  assign req_d = d_read | d_write;

  rr_pick2 u_pick (
    .req_i  (i_read),
    .req_d  (req_d),
    .last_d (last_d),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_d     <= ~D_FIRST;
      d_is_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read | req_d) begin
            if (pick_d) begin
              state      <= SERV_D;
              d_is_write <= d_write;
            end else begin
              state <= SERV_I;
            end
          end
        end
        // Memory cannot abort, so the grant holds until mem_resp even if the requester drops.
        SERV_I: begin
          if (mem_resp) begin
            state  <= GAP;
            last_d <= 1'b0;
          end
        end
        SERV_D: begin
          if (mem_resp) begin
            state  <= GAP;
            last_d <= 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    i_rdata     = '0;
    i_resp      = 1'b0;
    d_rdata     = '0;
    d_resp      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    grant       = GRANT_NONE;
    case (state)
      SERV_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_rdata     = mem_rdata;
        i_resp      = mem_resp;
        grant       = GRANT_I;
      end
      SERV_D: begin
        mem_read    = ~d_is_write;
        mem_write   = d_is_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_rdata     = mem_rdata;
        d_resp      = mem_resp;
        grant       = GRANT_D;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [1:0]   grant;

  int checks;
  int failures;

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .D_FIRST(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .grant       (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] line_a5;
    logic [255:0] line_wd;
    logic [255:0] line_rd;
    logic [1:0]   exp_g;
    checks    = 0;
    failures  = 0;
    line_a5   = {32{8'hA5}};
    line_wd   = {8{32'h12345678}};
    line_rd   = {8{32'hCAFEF00D}};
    rst       = 1'b0;
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    #2;
    chk("reset_grant", grant, 2'b00);
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // Lone icache read
    i_read = 1'b1;
    i_address = 32'h0000_1000;
    tick();
    chk("i_c1_mem_read", mem_read, 1'b1);
    chk("i_c1_addr", mem_address, 32'h0000_1000);
    chk("i_c1_grant", grant, 2'b01);
    tick();
    chk("i_c2_mem_read", mem_read, 1'b1);
    tick();
    chk("i_c3_mem_read", mem_read, 1'b1);
    tick();
    mem_resp = 1'b1;
    mem_rdata = line_a5;
    #1;
    chk("i_c4_mem_read", mem_read, 1'b1);
    chk("i_c4_resp", i_resp, 1'b1);
    chk("i_c4_rdata", i_rdata, line_a5);
    chk("i_c4_no_dresp", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    i_read = 1'b0;
    #1;
    chk("i_gap_grant", grant, 2'b00);
    chk("i_gap_mem_read", mem_read, 1'b0);
    chk("i_gap_resp", i_resp, 1'b0);
    tick();
    chk("i_idle_grant", grant, 2'b00);

    // Lone dcache write
    d_write = 1'b1;
    d_address = 32'h0000_2040;
    d_wdata = line_wd;
    tick();
    chk("dw_mem_write", mem_write, 1'b1);
    chk("dw_mem_read", mem_read, 1'b0);
    chk("dw_addr", mem_address, 32'h0000_2040);
    chk("dw_wdata", mem_wdata, line_wd);
    chk("dw_grant", grant, 2'b10);
    tick();
    mem_resp = 1'b1;
    mem_rdata = line_rd;
    #1;
    chk("dw_resp", d_resp, 1'b1);
    chk("dw_rdata", d_rdata, line_rd);
    chk("dw_no_iresp", i_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    d_write = 1'b0;
    #1;
    chk("dw_gap_mem_write", mem_write, 1'b0);
    chk("dw_gap_addr", mem_address, 32'h0);
    chk("dw_gap_grant", grant, 2'b00);
    tick();
    chk("dw_idle_grant", grant, 2'b00);

    // Reset restores the dcache-first tie break; both then held high -> D, I, D, I
    rst = 1'b0;
    tick();
    rst = 1'b1;
    i_read = 1'b1;
    i_address = 32'h0000_3000;
    d_read = 1'b1;
    d_address = 32'h0000_4000;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      chk("alt_grant", grant, exp_g);
      chk("alt_mem_read", mem_read, 1'b1);
      chk("alt_addr", mem_address, (k % 2 == 0) ? 32'h0000_4000 : 32'h0000_3000);
      tick();
      mem_resp = 1'b1;
      mem_rdata = line_rd;
      #1;
      chk("alt_iresp", i_resp, (k % 2 == 1) ? 1'b1 : 1'b0);
      chk("alt_dresp", d_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      mem_resp = 1'b0;
      #1;
      chk("alt_gap_grant", grant, 2'b00);
      tick();
      chk("alt_idle_grant", grant, 2'b00);
    end
    i_read = 1'b0;
    d_read = 1'b0;
    tick();

    // Asynchronous reset in the middle of a dcache write
    d_write = 1'b1;
    d_address = 32'h0000_5000;
    tick();
    chk("rst_pre_mem_write", mem_write, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_mem_write", mem_write, 1'b0);
    chk("rst_async_grant", grant, 2'b00);
    chk("rst_async_addr", mem_address, 32'h0);
    d_write = 1'b0;
    tick();
    rst = 1'b1;
    i_read = 1'b1;
    i_address = 32'h0000_6000;
    tick();
    chk("post_rst_grant", grant, 2'b01);
    chk("post_rst_addr", mem_address, 32'h0000_6000);
    mem_resp = 1'b1;
    #1;
    chk("post_rst_iresp", i_resp, 1'b1);
    tick();
    mem_resp = 1'b0;
    i_read = 1'b0;
    tick();

    // Read and write together is a write; stray mem_resp in GAP/IDLE is ignored
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h0000_7000;
    tick();
    chk("rw_mem_write", mem_write, 1'b1);
    chk("rw_mem_read", mem_read, 1'b0);
    mem_resp = 1'b1;
    #1;
    chk("rw_resp", d_resp, 1'b1);
    tick();
    d_read = 1'b0;
    d_write = 1'b0;
    #1;
    chk("gap_stray_dresp", d_resp, 1'b0);
    chk("gap_stray_grant", grant, 2'b00);
    tick();
    chk("idle_stray_iresp", i_resp, 1'b0);
    chk("idle_stray_dresp", d_resp, 1'b0);
    chk("idle_stray_grant", grant, 2'b00);
    tick();
    mem_resp = 1'b0;
    #1;
    chk("idle_after_stray_grant", grant, 2'b00);
    chk("idle_after_stray_mem_read", mem_read, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
